// File: rtl/digilock_pkg.sv
// Shared types and constants for the DigiLock core: FSM states, keypad/BCD widths,
// and the one-hot validity helper used by the keypad front end.
package digilock_pkg;

  localparam int DIGIT_W = 4;
  localparam int KEY_W   = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_LOCKOUT
  } state_t;

  function automatic logic onehot_valid(input logic [KEY_W-1:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/digilock_key_encoder.sv
// Keypad front end: registers the raw keypad, emits a one-cycle press strobe on a clean
// 0 -> one-hot transition (held or multi-hot keys give nothing), with the digit in BCD.
module digilock_key_encoder
  import digilock_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [KEY_W-1:0]   codificador,
  output logic               press_vld,
  output logic [DIGIT_W-1:0] press_dat
);

  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] prev_q, prev_d;

  always_comb begin
    key_d  = codificador;
    prev_d = key_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_q  <= '0;
      prev_q <= '0;
    end else begin
      key_q  <= key_d;
      prev_q <= prev_d;
    end
  end

  always_comb begin
    press_vld = onehot_valid(key_q) && (prev_q == '0);
    press_dat = '0;
    for (int k = 0; k < KEY_W; k++) begin
      if (key_q[k]) press_dat = DIGIT_W'(k);
    end
  end

endmodule

// File: rtl/digilock_param.sv
// DigiLock core: collects N_DIGITS key presses, then programs or verifies the code, drives
// the timed unlock window and the failure lockout. All outputs are registered.
module digilock_param
  import digilock_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int MAX_TRIES   = 3,
  parameter int OPEN_CYCLES = 20,
  parameter int LOCK_CYCLES = 100
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [KEY_W-1:0]              codificador,
  input  logic                          modo,
  output logic                          fechadura,
  output logic                          comparador,
  output logic                          erro,
  output logic                          bloqueado,
  output logic [$clog2(N_DIGITS+1)-1:0] contagem,
  output logic [3:0]                    falhas
);

  localparam int CNT_W   = $clog2(N_DIGITS + 1);
  localparam int BUF_W   = N_DIGITS * DIGIT_W;
  localparam int TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [3:0]       FAL_MAX   = 4'(MAX_TRIES);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_DIGITS - 1);

  logic               press_vld;
  logic [DIGIT_W-1:0] press_dat;

  digilock_key_encoder u_key_encoder (
    .clock       (clock),
    .reset       (reset),
    .codificador (codificador),
    .press_vld   (press_vld),
    .press_dat   (press_dat)
  );

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [BUF_W-1:0]   code_q, code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         fal_q, fal_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               modo_q, modo_d;
  logic               cmp_q, cmp_d;
  logic               err_q, err_d;
  logic               open_q, open_d;
  logic               blk_q, blk_d;

  logic [BUF_W-1:0]   buf_shift;
  logic [3:0]         fal_inc;

  // Digits enter at the low nibble so the first one ends up as the MSD.
  assign buf_shift = (buf_q << DIGIT_W) | BUF_W'(press_dat);
  assign fal_inc   = (fal_q >= FAL_MAX) ? FAL_MAX : fal_q + 4'd1;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    fal_d   = fal_q;
    tmr_d   = tmr_q;
    modo_d  = modo;
    cmp_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (press_vld) begin
          buf_d   = buf_shift;
          cnt_d   = CNT_W'(1);
          state_d = (N_DIGITS == 1) ? ST_CHECK : ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        // A mode flip mid-sequence discards the partial entry.
        if (modo != modo_q) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (press_vld) begin
          buf_d = buf_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (modo) begin
          code_d  = buf_q;
          state_d = ST_IDLE;
        end else if (buf_q == code_q) begin
          cmp_d   = 1'b1;
          fal_d   = '0;
          tmr_d   = OPEN_LOAD;
          state_d = ST_OPEN;
        end else begin
          err_d = 1'b1;
          fal_d = fal_inc;
          if (fal_inc == FAL_MAX) begin
            tmr_d   = LOCK_LOAD;
            state_d = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_OPEN: begin
        if (tmr_q == '0) state_d = ST_IDLE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end

      ST_LOCKOUT: begin
        if (tmr_q == '0) begin
          fal_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    open_d = (state_d == ST_OPEN);
    blk_d  = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      fal_q   <= '0;
      tmr_q   <= '0;
      modo_q  <= 1'b0;
      cmp_q   <= 1'b0;
      err_q   <= 1'b0;
      open_q  <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      fal_q   <= fal_d;
      tmr_q   <= tmr_d;
      modo_q  <= modo_d;
      cmp_q   <= cmp_d;
      err_q   <= err_d;
      open_q  <= open_d;
      blk_q   <= blk_d;
    end
  end

  assign fechadura  = open_q;
  assign comparador = cmp_q;
  assign erro       = err_q;
  assign bloqueado  = blk_q;
  assign contagem   = cnt_q;
  assign falhas     = fal_q;

endmodule

// File: tb/tb_digilock_param.sv
// Bench for digilock_param: directed scenarios plus randomized program/verify traffic
// checked against a code/failure-count model; second instance covers N_DIGITS=6, MAX_TRIES=1.
module tb_digilock_param;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reset2 = 1'b1;
  logic [9:0]  codificador = '0;
  logic        modo = 1'b0;

  logic        fechadura, comparador, erro, bloqueado;
  logic [2:0]  contagem;
  logic [3:0]  falhas;
  logic        fechadura2, comparador2, erro2, bloqueado2;
  logic [2:0]  contagem2;
  logic [3:0]  falhas2;

  int n_checks = 0;
  int n_pass   = 0;

  // model state for the default instance
  logic [31:0] model_code;
  int          model_fail;

  always #5 clock = ~clock;

  digilock_param dut (
    .clock(clock), .reset(reset), .codificador(codificador), .modo(modo),
    .fechadura(fechadura), .comparador(comparador), .erro(erro), .bloqueado(bloqueado),
    .contagem(contagem), .falhas(falhas)
  );

  digilock_param #(.N_DIGITS(6), .MAX_TRIES(1), .OPEN_CYCLES(20), .LOCK_CYCLES(100)) dut2 (
    .clock(clock), .reset(reset2), .codificador(codificador), .modo(modo),
    .fechadura(fechadura2), .comparador(comparador2), .erro(erro2), .bloqueado(bloqueado2),
    .contagem(contagem2), .falhas(falhas2)
  );

  task automatic enter_seq(input logic [31:0] bcd, input int n);
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      d = bcd[4*(n-1-i) +: 4];
      codificador = '0;
      codificador[d] = 1'b1;
      repeat (2) @(negedge clock);
      codificador = '0;
      if (i != n - 1) repeat (2) @(negedge clock);
    end
  endtask

  // res: 0 = no pulse within the budget, 1 = comparador, 2 = erro
  task automatic wait_result(input bit sel, output int res);
    res = 0;
    for (int i = 0; i < 30 && res == 0; i++) begin
      @(negedge clock);
      if (sel ? comparador2 : comparador) res = 1;
      else if (sel ? erro2 : erro) res = 2;
    end
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return fechadura;
      1:       return bloqueado;
      default: return bloqueado2;
    endcase
  endfunction

  task automatic count_high(input int which, output int c);
    c = 0;
    while (sig_of(which) && c < 300) begin
      c++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_checks++; if (fechadura !== 1'b0) $display("FAIL reset_fechadura got %b want 0", fechadura); else n_pass++;
    n_checks++; if (comparador !== 1'b0 || erro !== 1'b0) $display("FAIL reset_pulses got %b%b want 00", comparador, erro); else n_pass++;
    n_checks++; if (bloqueado !== 1'b0) $display("FAIL reset_bloqueado got %b want 0", bloqueado); else n_pass++;
    reset = 1'b0;
    reset2 = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (contagem !== 3'd0) $display("FAIL reset_contagem got %0d want 0", contagem); else n_pass++;
    n_checks++; if (falhas !== 4'd0) $display("FAIL reset_falhas got %0d want 0", falhas); else n_pass++;
  endtask

  task automatic test_program_verify;
    int res, c;
    modo = 1'b1;
    enter_seq(32'h0275, 4);
    model_code = 32'h0275;
    wait_result(0, res);
    n_checks++; if (res !== 0) $display("FAIL prog_no_pulse got %0d want 0", res); else n_pass++;
    modo = 1'b0;
    repeat (2) @(negedge clock);
    enter_seq(32'h0275, 4);
    wait_result(0, res);
    n_checks++; if (res !== 1) $display("FAIL verify_ok_result got %0d want 1", res); else n_pass++;
    n_checks++; if (falhas !== 4'd0) $display("FAIL verify_ok_falhas got %0d want 0", falhas); else n_pass++;
    count_high(0, c);
    n_checks++; if (c !== 20) $display("FAIL open_cycles got %0d want 20", c); else n_pass++;
    model_fail = 0;
  endtask

  task automatic test_wrong_lockout;
    int res, c;
    for (int t = 1; t <= 3; t++) begin
      enter_seq(32'h0187, 4);
      wait_result(0, res);
      n_checks++; if (res !== 2) $display("FAIL wrong_result_%0d got %0d want 2", t, res); else n_pass++;
      n_checks++; if (falhas !== 4'(t)) $display("FAIL wrong_falhas_%0d got %0d want %0d", t, falhas, t); else n_pass++;
      if (t < 3) repeat (2) @(negedge clock);
    end
    n_checks++; if (bloqueado !== 1'b1) $display("FAIL lockout_entered got %b want 1", bloqueado); else n_pass++;
    count_high(1, c);
    n_checks++; if (c !== 100) $display("FAIL lock_cycles got %0d want 100", c); else n_pass++;
    n_checks++; if (falhas !== 4'd0) $display("FAIL lockout_falhas_clear got %0d want 0", falhas); else n_pass++;
    model_fail = 0;
  endtask

  task automatic test_key_hygiene;
    codificador = 10'h004;
    repeat (10) @(negedge clock);
    codificador = 10'h005;
    repeat (5) @(negedge clock);
    codificador = '0;
    repeat (3) @(negedge clock);
    n_checks++; if (contagem !== 3'd1) $display("FAIL hygiene_contagem got %0d want 1", contagem); else n_pass++;
    modo = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++; if (contagem !== 3'd0) $display("FAIL hygiene_clear got %0d want 0", contagem); else n_pass++;
    modo = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_mode_change;
    int pulses;
    enter_seq(32'h02, 2);
    @(negedge clock);
    n_checks++; if (contagem !== 3'd2) $display("FAIL mode_contagem_before got %0d want 2", contagem); else n_pass++;
    modo = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (comparador || erro) pulses++;
    end
    n_checks++; if (contagem !== 3'd0) $display("FAIL mode_contagem_after got %0d want 0", contagem); else n_pass++;
    n_checks++; if (pulses !== 0) $display("FAIL mode_no_pulse got %0d want 0", pulses); else n_pass++;
    modo = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_async_reset;
    int res, c;
    enter_seq(model_code, 4);
    wait_result(0, res);
    n_checks++; if (res !== 1) $display("FAIL areset_open got %0d want 1", res); else n_pass++;
    repeat (4) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (fechadura !== 1'b0) $display("FAIL areset_fechadura got %b want 0", fechadura); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    model_code = 32'h0000;
    model_fail = 0;
    repeat (2) @(negedge clock);
    enter_seq(32'h0000, 4);
    wait_result(0, res);
    n_checks++; if (res !== 1) $display("FAIL areset_zero_code got %0d want 1", res); else n_pass++;
    count_high(0, c);
  endtask

  task automatic test_random;
    int res, c, op, exp_res;
    logic [31:0] code;
    for (int it = 0; it < 10; it++) begin
      op = $urandom_range(2);
      code = '0;
      for (int k = 0; k < 4; k++) code[4*k +: 4] = 4'($urandom_range(9));
      if (op == 1) code = model_code;
      if (op == 0) begin
        modo = 1'b1;
        enter_seq(code, 4);
        wait_result(0, res);
        n_checks++; if (res !== 0) $display("FAIL rand_prog_%0d got %0d want 0", it, res); else n_pass++;
        model_code = code;
        modo = 1'b0;
        repeat (2) @(negedge clock);
      end else begin
        exp_res = (code == model_code) ? 1 : 2;
        enter_seq(code, 4);
        wait_result(0, res);
        n_checks++; if (res !== exp_res) $display("FAIL rand_verify_%0d got %0d want %0d", it, res, exp_res); else n_pass++;
        model_fail = (exp_res == 1) ? 0 : model_fail + 1;
        n_checks++; if (falhas !== 4'(model_fail)) $display("FAIL rand_falhas_%0d got %0d want %0d", it, falhas, model_fail); else n_pass++;
        if (exp_res == 1) begin
          count_high(0, c);
          n_checks++; if (c !== 20) $display("FAIL rand_open_%0d got %0d want 20", it, c); else n_pass++;
        end else if (model_fail == 3) begin
          count_high(1, c);
          n_checks++; if (c !== 100) $display("FAIL rand_lock_%0d got %0d want 100", it, c); else n_pass++;
          model_fail = 0;
        end
        repeat (2) @(negedge clock);
      end
    end
  endtask

  task automatic test_param_sweep;
    int res, c;
    codificador = '0;
    reset2 = 1'b1;
    repeat (2) @(negedge clock);
    reset2 = 1'b0;
    modo = 1'b1;
    repeat (2) @(negedge clock);
    enter_seq(32'h123456, 6);
    wait_result(1, res);
    n_checks++; if (res !== 0) $display("FAIL p6_prog got %0d want 0", res); else n_pass++;
    modo = 1'b0;
    repeat (2) @(negedge clock);
    enter_seq(32'h123450, 6);
    wait_result(1, res);
    n_checks++; if (res !== 2) $display("FAIL p6_wrong got %0d want 2", res); else n_pass++;
    n_checks++; if (bloqueado2 !== 1'b1) $display("FAIL p6_lockout got %b want 1", bloqueado2); else n_pass++;
    n_checks++; if (falhas2 !== 4'd1) $display("FAIL p6_falhas got %0d want 1", falhas2); else n_pass++;
    count_high(2, c);
    n_checks++; if (c !== 100) $display("FAIL p6_lock_cycles got %0d want 100", c); else n_pass++;
    repeat (2) @(negedge clock);
    enter_seq(32'h123456, 6);
    wait_result(1, res);
    n_checks++; if (res !== 1) $display("FAIL p6_right got %0d want 1", res); else n_pass++;
  endtask

  initial begin
    model_code = '0;
    model_fail = 0;
    test_reset();
    test_program_verify();
    test_wrong_lockout();
    test_key_hygiene();
    test_mode_change();
    test_async_reset();
    test_random();
    test_param_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
